// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the EX stage of the RV32 pipeline.
//   - ALUOp encodings driven by the main decoder
//   - funct3 / funct7 constants used by the ALU decoder and MUL detection
//   - alu_ctl_t    : internal ALU operation select
//   - mul_state_t  : iterative multiplier sequencer states
//   - forwarding select codes (used when EX_FWD_EN is defined)
//   - alu_decode() : ALUOp/funct7/funct3 -> alu_ctl_t
package ex_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_ctl_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_t;

  // Map the decoder's ALUOp plus funct fields onto one ALU operation.
  // M-extension encodings (funct7 = 0000001) fall back to add; MUL itself is
  // detected separately and routed to the sequential multiplier.
  function automatic alu_ctl_t alu_decode(input logic [1:0] alu_op,
                                          input logic [6:0] funct7,
                                          input logic [2:0] funct3);
    alu_ctl_t ctl;
    ctl = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: ctl = ALU_ADD;
      ALUOP_SUB: ctl = ALU_SUB;
      ALUOP_RTYPE: begin
        if (funct7 == F7_MULDIV) begin
          ctl = ALU_ADD;
        end else begin
          case (funct3)
            F3_ADD:  ctl = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
            F3_SLL:  ctl = ALU_SLL;
            F3_SLT:  ctl = ALU_SLT;
            F3_SLTU: ctl = ALU_SLTU;
            F3_XOR:  ctl = ALU_XOR;
            F3_SR:   ctl = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            F3_OR:   ctl = ALU_OR;
            F3_AND:  ctl = ALU_AND;
            default: ctl = ALU_ADD;
          endcase
        end
      end
      ALUOP_ITYPE: begin
        // funct7 is immediate bits here; only bit 5 matters (srai vs srli)
        case (funct3)
          F3_ADD:  ctl = ALU_ADD;
          F3_SLL:  ctl = ALU_SLL;
          F3_SLT:  ctl = ALU_SLT;
          F3_SLTU: ctl = ALU_SLTU;
          F3_XOR:  ctl = ALU_XOR;
          F3_SR:   ctl = funct7[5] ? ALU_SRA : ALU_SRL;
          F3_OR:   ctl = ALU_OR;
          F3_AND:  ctl = ALU_AND;
          default: ctl = ALU_ADD;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/ex_mul_seq.sv
// ex_mul_seq: iterative shift-add multiplier, one multiplier bit per cycle.
// Produces the low XLEN bits of a * b.
//   clk, reset : clock, async active-high reset
//   start      : MUL presented; only sampled in IDLE
//   abort      : squash; returns to IDLE from any state, wins over start
//   a, b       : multiplicand / multiplier, captured on start
//   busy       : high in BUSY
//   done       : high for the single DONE cycle; product valid then
//   product    : low XLEN bits of the product
module ex_mul_seq
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  mul_state_t      state_r;
  logic [CW-1:0]   cnt_r;
  logic [XLEN-1:0] acc_r;
  logic [XLEN-1:0] mcand_r;
  logic [XLEN-1:0] mplr_r;

  // Sequencer: IDLE captures operands, BUSY adds/shifts XLEN times, DONE lasts one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      acc_r   <= {XLEN{1'b0}};
      mcand_r <= {XLEN{1'b0}};
      mplr_r  <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !abort) begin
            mcand_r <= a;
            mplr_r  <= b;
            acc_r   <= {XLEN{1'b0}};
            cnt_r   <= CW'(XLEN - 1);
            state_r <= BUSY;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (abort) begin
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
          end else begin
            if (mplr_r[0]) begin
              acc_r <= acc_r + mcand_r;
            end else begin
              acc_r <= acc_r;
            end
            mcand_r <= {mcand_r[XLEN-2:0], 1'b0};
            mplr_r  <= {1'b0, mplr_r[XLEN-1:1]};
            // the step taken with cnt_r == 0 is the last of XLEN steps
            if (cnt_r == {CW{1'b0}}) begin
              state_r <= DONE;
            end else begin
              cnt_r   <= cnt_r - CW'(1);
            end
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  assign busy    = (state_r == BUSY);
  assign done    = (state_r == DONE);
  assign product = acc_r;

endmodule

// File: rtl/execute.sv
// execute: EX stage of the 5-stage RV32 pipeline. ALU, branch-target add,
// iterative MUL with front-end stall, and the EX/MEM pipeline register.
// Optional feature macro: EX_FWD_EN (adds operand forwarding ports).
// Ports:
//   clk, reset               : clock, async active-high reset
//   Flush_in                 : squash the instruction in EX
//   PC_in, ReadData1_in, ReadData2_in, Immediate_in : ID/EX data
//   funct7_in, funct3_in, Rd_in, Ctl_ALUSrc_in, Ctl_ALUOp_in : ID/EX decode
//   Ctl_{MemtoReg,RegWrite,MemRead,MemWrite,Branch}_in : controls for MEM/WB
//   ForwardA/B, Fwd_MEM_data, Fwd_WB_data (EX_FWD_EN only) : forwarding
//   Stall_out                : combinational; holds PC, IF/ID and ID/EX
//   Ctl_*_out, Rd_out, Zero_out, ALUresult_out, Write_Data_out, PCimm_out :
//                              EX/MEM register
module execute
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Flush_in,
  input  logic [XLEN-1:0] PC_in,
  input  logic [XLEN-1:0] ReadData1_in,
  input  logic [XLEN-1:0] ReadData2_in,
  input  logic [XLEN-1:0] Immediate_in,
  input  logic [6:0]      funct7_in,
  input  logic [2:0]      funct3_in,
  input  logic [4:0]      Rd_in,
  input  logic            Ctl_ALUSrc_in,
  input  logic [1:0]      Ctl_ALUOp_in,
  input  logic            Ctl_MemtoReg_in,
  input  logic            Ctl_RegWrite_in,
  input  logic            Ctl_MemRead_in,
  input  logic            Ctl_MemWrite_in,
  input  logic            Ctl_Branch_in,
`ifdef EX_FWD_EN
  input  logic [1:0]      ForwardA,
  input  logic [1:0]      ForwardB,
  input  logic [XLEN-1:0] Fwd_MEM_data,
  input  logic [XLEN-1:0] Fwd_WB_data,
`endif
  output logic            Stall_out,
  output logic            Ctl_MemtoReg_out,
  output logic            Ctl_RegWrite_out,
  output logic            Ctl_MemRead_out,
  output logic            Ctl_MemWrite_out,
  output logic            Ctl_Branch_out,
  output logic [4:0]      Rd_out,
  output logic            Zero_out,
  output logic [XLEN-1:0] ALUresult_out,
  output logic [XLEN-1:0] Write_Data_out,
  output logic [XLEN-1:0] PCimm_out
);

  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] rs1_s;
  logic [XLEN-1:0] rs2_s;
  logic [XLEN-1:0] op_b_s;
  logic [XLEN-1:0] alu_res_s;
  logic [SHW-1:0]  shamt_s;
  alu_ctl_t        alu_ctl_s;
  logic            is_mul_s;
  logic            mul_busy_s;
  logic            mul_done_s;
  logic            mul_accept_s;
  logic [XLEN-1:0] mul_product_s;
  logic [4:0]      ctl_in_s;
  logic [4:0]      ctl_hold_r;
  logic [4:0]      rd_hold_r;
  logic [4:0]      ctl_nxt_s;
  logic [4:0]      rd_nxt_s;
  logic            zero_nxt_s;
  logic [XLEN-1:0] result_nxt_s;
  logic [XLEN-1:0] wdata_nxt_s;
  logic [XLEN-1:0] pcimm_nxt_s;

`ifdef EX_FWD_EN
  // Operand forwarding muxes; the forwarded rs2 also becomes the store data.
  always_comb begin
    rs1_s = ReadData1_in;
    rs2_s = ReadData2_in;
    case (ForwardA)
      FWD_MEM: rs1_s = Fwd_MEM_data;
      FWD_WB:  rs1_s = Fwd_WB_data;
      default: rs1_s = ReadData1_in;
    endcase
    case (ForwardB)
      FWD_MEM: rs2_s = Fwd_MEM_data;
      FWD_WB:  rs2_s = Fwd_WB_data;
      default: rs2_s = ReadData2_in;
    endcase
  end
`else
  assign rs1_s = ReadData1_in;
  assign rs2_s = ReadData2_in;
`endif

  assign op_b_s    = Ctl_ALUSrc_in ? Immediate_in : rs2_s;
  assign shamt_s   = op_b_s[SHW-1:0];
  assign alu_ctl_s = alu_decode(Ctl_ALUOp_in, funct7_in, funct3_in);
  assign is_mul_s  = (Ctl_ALUOp_in == ALUOP_RTYPE) && (funct7_in == F7_MULDIV) &&
                     (funct3_in == F3_ADD);
  assign ctl_in_s  = {Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in,
                      Ctl_MemWrite_in, Ctl_Branch_in};

  // A MUL is accepted only from IDLE, so the copy still presented in DONE
  // (ID/EX was held by the stall) does not start a second multiply.
  assign mul_accept_s = is_mul_s && !mul_busy_s && !mul_done_s && !Flush_in;
  assign Stall_out    = !reset && !Flush_in && (mul_accept_s || mul_busy_s);

  // Single-cycle ALU.
  always_comb begin
    alu_res_s = {XLEN{1'b0}};
    case (alu_ctl_s)
      ALU_ADD:  alu_res_s = rs1_s + op_b_s;
      ALU_SUB:  alu_res_s = rs1_s - op_b_s;
      ALU_SLL:  alu_res_s = rs1_s << shamt_s;
      ALU_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(rs1_s) < $signed(op_b_s))};
      ALU_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (rs1_s < op_b_s)};
      ALU_XOR:  alu_res_s = rs1_s ^ op_b_s;
      ALU_SRL:  alu_res_s = rs1_s >> shamt_s;
      ALU_SRA:  alu_res_s = $signed(rs1_s) >>> shamt_s;
      ALU_OR:   alu_res_s = rs1_s | op_b_s;
      ALU_AND:  alu_res_s = rs1_s & op_b_s;
      default:  alu_res_s = {XLEN{1'b0}};
    endcase
  end

  ex_mul_seq #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (is_mul_s),
    .abort   (Flush_in),
    .a       (rs1_s),
    .b       (rs2_s),
    .busy    (mul_busy_s),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  // Keep the MUL's controls and rd while the bubbles go down the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctl_hold_r <= 5'b00000;
      rd_hold_r  <= 5'b00000;
    end else if (mul_accept_s) begin
      ctl_hold_r <= ctl_in_s;
      rd_hold_r  <= Rd_in;
    end else begin
      ctl_hold_r <= ctl_hold_r;
      rd_hold_r  <= rd_hold_r;
    end
  end

  // EX/MEM next value: flush > MUL result > MUL bubble > normal instruction.
  always_comb begin
    ctl_nxt_s    = 5'b00000;
    rd_nxt_s     = 5'b00000;
    zero_nxt_s   = 1'b0;
    result_nxt_s = {XLEN{1'b0}};
    wdata_nxt_s  = {XLEN{1'b0}};
    pcimm_nxt_s  = {XLEN{1'b0}};
    if (Flush_in) begin
      ctl_nxt_s = 5'b00000;
    end else if (mul_done_s) begin
      ctl_nxt_s    = ctl_hold_r;
      rd_nxt_s     = rd_hold_r;
      result_nxt_s = mul_product_s;
      zero_nxt_s   = (mul_product_s == {XLEN{1'b0}});
    end else if (mul_accept_s || mul_busy_s) begin
      ctl_nxt_s = 5'b00000;
    end else begin
      ctl_nxt_s    = ctl_in_s;
      rd_nxt_s     = Rd_in;
      result_nxt_s = alu_res_s;
      zero_nxt_s   = (alu_res_s == {XLEN{1'b0}});
      wdata_nxt_s  = rs2_s;
      pcimm_nxt_s  = PC_in + {Immediate_in[XLEN-2:0], 1'b0};
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out,
       Ctl_MemWrite_out, Ctl_Branch_out} <= 5'b00000;
      Rd_out         <= 5'b00000;
      Zero_out       <= 1'b0;
      ALUresult_out  <= {XLEN{1'b0}};
      Write_Data_out <= {XLEN{1'b0}};
      PCimm_out      <= {XLEN{1'b0}};
    end else begin
      {Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out,
       Ctl_MemWrite_out, Ctl_Branch_out} <= ctl_nxt_s;
      Rd_out         <= rd_nxt_s;
      Zero_out       <= zero_nxt_s;
      ALUresult_out  <= result_nxt_s;
      Write_Data_out <= wdata_nxt_s;
      PCimm_out      <= pcimm_nxt_s;
    end
  end

endmodule

// File: tb/tb_execute.sv
// tb_execute: directed, scoreboard-based bench for the EX stage.
// Expected EX/MEM contents are queued when an instruction is driven and
// compared one edge later.
module tb_execute;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            Flush_in;
  logic [XLEN-1:0] PC_in, ReadData1_in, ReadData2_in, Immediate_in;
  logic [6:0]      funct7_in;
  logic [2:0]      funct3_in;
  logic [4:0]      Rd_in;
  logic            Ctl_ALUSrc_in;
  logic [1:0]      Ctl_ALUOp_in;
  logic            Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_Branch_in;
`ifdef EX_FWD_EN
  logic [1:0]      ForwardA, ForwardB;
  logic [XLEN-1:0] Fwd_MEM_data, Fwd_WB_data;
`endif
  logic            Stall_out;
  logic            Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out, Ctl_MemWrite_out, Ctl_Branch_out;
  logic [4:0]      Rd_out;
  logic            Zero_out;
  logic [XLEN-1:0] ALUresult_out, Write_Data_out, PCimm_out;

  always #5 clk = ~clk;

  execute #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .Flush_in(Flush_in), .PC_in(PC_in),
    .ReadData1_in(ReadData1_in), .ReadData2_in(ReadData2_in), .Immediate_in(Immediate_in),
    .funct7_in(funct7_in), .funct3_in(funct3_in), .Rd_in(Rd_in),
    .Ctl_ALUSrc_in(Ctl_ALUSrc_in), .Ctl_ALUOp_in(Ctl_ALUOp_in),
    .Ctl_MemtoReg_in(Ctl_MemtoReg_in), .Ctl_RegWrite_in(Ctl_RegWrite_in),
    .Ctl_MemRead_in(Ctl_MemRead_in), .Ctl_MemWrite_in(Ctl_MemWrite_in), .Ctl_Branch_in(Ctl_Branch_in),
`ifdef EX_FWD_EN
    .ForwardA(ForwardA), .ForwardB(ForwardB), .Fwd_MEM_data(Fwd_MEM_data), .Fwd_WB_data(Fwd_WB_data),
`endif
    .Stall_out(Stall_out),
    .Ctl_MemtoReg_out(Ctl_MemtoReg_out), .Ctl_RegWrite_out(Ctl_RegWrite_out),
    .Ctl_MemRead_out(Ctl_MemRead_out), .Ctl_MemWrite_out(Ctl_MemWrite_out), .Ctl_Branch_out(Ctl_Branch_out),
    .Rd_out(Rd_out), .Zero_out(Zero_out), .ALUresult_out(ALUresult_out),
    .Write_Data_out(Write_Data_out), .PCimm_out(PCimm_out)
  );

  typedef struct {
    string       tag;
    logic [4:0]  ctl;      // {MemtoReg, RegWrite, MemRead, MemWrite, Branch}
    logic        chk_data; // rd / zero / result compared
    logic [4:0]  rd;
    logic        zero;
    logic [31:0] result;
    logic        chk_aux;  // store data / branch target compared
    logic [31:0] wdata;
    logic [31:0] pcimm;
  } exp_t;

  exp_t sb[$];
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ctl_out();
    return {Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out, Ctl_MemWrite_out, Ctl_Branch_out};
  endfunction

  task automatic set_instr(input logic [1:0] aluop, input logic [6:0] f7, input logic [2:0] f3,
                           input logic alusrc, input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] rd,
                           input logic [4:0] ctl);
    Ctl_ALUOp_in = aluop; funct7_in = f7; funct3_in = f3; Ctl_ALUSrc_in = alusrc;
    ReadData1_in = rs1; ReadData2_in = rs2; Immediate_in = imm; PC_in = pc; Rd_in = rd;
    {Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_Branch_in} = ctl;
`ifdef EX_FWD_EN
    ForwardA = 2'b00; ForwardB = 2'b00; Fwd_MEM_data = 32'd0; Fwd_WB_data = 32'd0;
`endif
  endtask

  task automatic push(input string tag, input logic [4:0] ctl, input logic chk_data,
                      input logic [4:0] rd, input logic [31:0] result, input logic chk_aux,
                      input logic [31:0] wdata, input logic [31:0] pcimm);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.chk_data = chk_data; e.rd = rd;
    e.zero = (result == 32'd0); e.result = result;
    e.chk_aux = chk_aux; e.wdata = wdata; e.pcimm = pcimm;
    sb.push_back(e);
  endtask

  task automatic push_bubble(input string tag);
    push(tag, 5'b00000, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0);
  endtask

  // Advance one edge, then compare EX/MEM against the oldest expectation.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".ctl"}, 32'(ctl_out()), 32'(e.ctl));
      if (e.chk_data) begin
        chk({e.tag, ".rd"}, 32'(Rd_out), 32'(e.rd));
        chk({e.tag, ".zero"}, 32'(Zero_out), 32'(e.zero));
        chk({e.tag, ".result"}, ALUresult_out, e.result);
      end
      if (e.chk_aux) begin
        chk({e.tag, ".wdata"}, Write_Data_out, e.wdata);
        chk({e.tag, ".pcimm"}, PCimm_out, e.pcimm);
      end
    end
  endtask

  task automatic alu_op(input string tag, input logic [1:0] aluop, input logic [6:0] f7,
                        input logic [2:0] f3, input logic alusrc, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] pc,
                        input logic [4:0] rd, input logic [4:0] ctl, input logic [31:0] exp_res);
    set_instr(aluop, f7, f3, alusrc, rs1, rs2, imm, pc, rd, ctl);
    #1;
    chk({tag, ".stall"}, 32'(Stall_out), 32'd0);
    push(tag, ctl, 1'b1, rd, exp_res, 1'b1, rs2, pc + (imm << 1));
    step();
  endtask

  task automatic nops(input int n);
    set_instr(2'b00, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'b00000);
    for (int i = 0; i < n; i++) begin
      push("nop", 5'b00000, 1'b1, 5'd0, 32'd0, 1'b1, 32'd0, 32'd0);
      step();
    end
  endtask

  // Full MUL: stall must last 33 cycles with bubbles, then the product lands.
  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_prod);
    int n;
    set_instr(2'b10, 7'b0000001, 3'b000, 1'b0, a, b, 32'd0, 32'd0, rd, 5'b01000);
    #1;
    n = 0;
    while (Stall_out === 1'b1 && n < 40) begin
      push_bubble({tag, ".bubble"});
      step();
      n++;
    end
    chk({tag, ".stall_cycles"}, 32'(n), 32'd33);
    push(tag, 5'b01000, 1'b1, rd, exp_prod, 1'b0, 32'd0, 32'd0);
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ctl"}, 32'(ctl_out()), 32'd0);
    chk({tag, ".rd"}, 32'(Rd_out), 32'd0);
    chk({tag, ".zero"}, 32'(Zero_out), 32'd0);
    chk({tag, ".result"}, ALUresult_out, 32'd0);
    chk({tag, ".wdata"}, Write_Data_out, 32'd0);
    chk({tag, ".pcimm"}, PCimm_out, 32'd0);
    chk({tag, ".stall"}, 32'(Stall_out), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    Flush_in = 1'b0;
    set_instr(2'b00, 7'd0, 3'd0, 1'b0, 32'd11, 32'd22, 32'd4, 32'h40, 5'd7, 5'b01000);
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // R-type and branch
    alu_op("sub",    2'b10, 7'b0100000, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 5'b01000, 32'hFFFFFFFE);
    alu_op("beq",    2'b01, 7'd0, 3'b000, 1'b0, 32'h1234, 32'h1234, 32'd8, 32'h100, 5'd0, 5'b00001, 32'd0);
    chk("beq.target", PCimm_out, 32'h110);
    alu_op("addwrap",2'b10, 7'd0, 3'b000, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd1, 5'b01000, 32'd0);
    alu_op("sll",    2'b10, 7'd0, 3'b001, 1'b0, 32'd1, 32'h24, 32'd0, 32'd0, 5'd2, 5'b01000, 32'd16);
    alu_op("slt",    2'b10, 7'd0, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd2, 5'b01000, 32'd1);
    alu_op("sltu",   2'b10, 7'd0, 3'b011, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd2, 5'b01000, 32'd0);
    alu_op("xor",    2'b10, 7'd0, 3'b100, 1'b0, 32'hF0F0, 32'hFF00, 32'd0, 32'd0, 5'd2, 5'b01000, 32'h0FF0);
    alu_op("srl",    2'b10, 7'd0, 3'b101, 1'b0, 32'h80000000, 32'd4, 32'd0, 32'd0, 5'd2, 5'b01000, 32'h08000000);
    alu_op("sra",    2'b10, 7'b0100000, 3'b101, 1'b0, 32'h80000000, 32'd4, 32'd0, 32'd0, 5'd2, 5'b01000, 32'hF8000000);
    alu_op("or",     2'b10, 7'd0, 3'b110, 1'b0, 32'hF0, 32'h0F, 32'd0, 32'd0, 5'd2, 5'b01000, 32'hFF);
    alu_op("and",    2'b10, 7'd0, 3'b111, 1'b0, 32'hF0, 32'h3C, 32'd0, 32'd0, 5'd2, 5'b01000, 32'h30);
    alu_op("mulh_as_add", 2'b10, 7'b0000001, 3'b001, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0, 5'd6, 5'b01000, 32'd7);
    // I-type: funct7 carries immediate bits
    alu_op("addi_f7", 2'b11, 7'b0100000, 3'b000, 1'b1, 32'd1, 32'h55, 32'h400, 32'd0, 5'd8, 5'b01000, 32'h401);
    alu_op("srai",   2'b11, 7'b0100000, 3'b101, 1'b1, 32'h80000000, 32'd0, 32'h404, 32'd0, 5'd8, 5'b01000, 32'hF8000000);
    alu_op("srli",   2'b11, 7'd0, 3'b101, 1'b1, 32'h80000000, 32'd0, 32'd4, 32'd0, 5'd8, 5'b01000, 32'h08000000);
    alu_op("slti",   2'b11, 7'b1111111, 3'b010, 1'b1, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 5'd8, 5'b01000, 32'd0);
    alu_op("sltiu",  2'b11, 7'b1111111, 3'b011, 1'b1, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 5'd8, 5'b01000, 32'd1);
    alu_op("sw",     2'b00, 7'd0, 3'b010, 1'b1, 32'h1000, 32'hDEAD, 32'd4, 32'h40, 5'd0, 5'b00010, 32'h1004);
    alu_op("lw",     2'b00, 7'd0, 3'b010, 1'b1, 32'h2000, 32'd0, 32'hFFFFFFFC, 32'h80, 5'd9, 5'b11100, 32'h1FFC);

    // MUL, then a back-to-back MUL
    run_mul("mul6x7", 32'd6, 32'd7, 5'd9, 32'd42);
    run_mul("mulneg", 32'hFFFFFFFF, 32'd2, 5'd10, 32'hFFFFFFFE);
    alu_op("after_mul", 2'b00, 7'd0, 3'b000, 1'b0, 32'd20, 32'd22, 32'd0, 32'd0, 5'd1, 5'b01000, 32'd42);

    // Flush while BUSY at cycle 10
    set_instr(2'b10, 7'b0000001, 3'b000, 1'b0, 32'd3, 32'd5, 32'd0, 32'd0, 5'd11, 5'b01000);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("flushmul.stall", 32'(Stall_out), 32'd1);
      push_bubble("flushmul.bubble");
      step();
    end
    Flush_in = 1'b1;
    #1;
    chk("flush.stall", 32'(Stall_out), 32'd0);
    push_bubble("flush.bubble");
    step();
    Flush_in = 1'b0;
    alu_op("post_flush_add", 2'b00, 7'd0, 3'b000, 1'b0, 32'd2, 32'd3, 32'd0, 32'd0, 5'd4, 5'b01000, 32'd5);
    // flush beats a freshly presented MUL
    set_instr(2'b10, 7'b0000001, 3'b000, 1'b0, 32'd9, 32'd9, 32'd0, 32'd0, 5'd12, 5'b01000);
    Flush_in = 1'b1;
    #1;
    chk("flush_newmul.stall", 32'(Stall_out), 32'd0);
    push_bubble("flush_newmul.bubble");
    step();
    Flush_in = 1'b0;
    nops(36);

    // Reset while BUSY (cycle 5)
    set_instr(2'b10, 7'b0000001, 3'b000, 1'b0, 32'd6, 32'd7, 32'd0, 32'd0, 5'd13, 5'b01000);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rstmul.stall", 32'(Stall_out), 32'd1);
      push_bubble("rstmul.bubble");
      step();
    end
    reset = 1'b1;
    #1;
    chk_all_zero("rst_mid_mul");
    sb.delete();
    #1;
    reset = 1'b0;
    alu_op("post_reset_or", 2'b10, 7'd0, 3'b110, 1'b0, 32'hF0, 32'h0F, 32'd0, 32'd0, 5'd5, 5'b01000, 32'hFF);
    nops(36);

`ifdef EX_FWD_EN
    set_instr(2'b00, 7'd0, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd14, 5'b01000);
    ForwardA = 2'b10; Fwd_MEM_data = 32'd100;
    push("fwd_mem_add", 5'b01000, 1'b1, 5'd14, 32'd101, 1'b1, 32'd1, 32'd0);
    step();
    set_instr(2'b00, 7'd0, 3'b010, 1'b1, 32'h200, 32'd1, 32'd0, 32'd0, 5'd0, 5'b00010);
    ForwardB = 2'b01; Fwd_WB_data = 32'hAB;
    push("fwd_wb_sw", 5'b00010, 1'b1, 5'd0, 32'h200, 1'b1, 32'hAB, 32'd0);
    step();
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/execute.md
Name: execute

Overview:
- EX stage of the 5-stage RV32 pipeline, directly upstream of the MEM stage.
- Takes ID/EX operands and controls. Performs ALU ops and branch-target add. Runs an iterative shift-add MUL (RV32M) that stalls the front end.
- Registers everything the MEM stage consumes into the EX/MEM register.

Parameters:
XLEN, 32, datapath width; also the MUL iteration count

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
Flush_in  in  1  squash the instruction in EX (PCSrc from MEM)
PC_in  in  XLEN  PC of the instruction
ReadData1_in  in  XLEN  rs1 value
ReadData2_in  in  XLEN  rs2 value
Immediate_in  in  XLEN  sign-extended immediate
funct7_in  in  7  instr[31:25]
funct3_in  in  3  instr[14:12]
Rd_in  in  5  destination register
Ctl_ALUSrc_in  in  1  0: rs2, 1: immediate
Ctl_ALUOp_in  in  2  00 add, 01 sub, 10 R-type, 11 I-type arith
Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_Branch_in  in  1 each  passed to EX/MEM
Stall_out  out  1  combinational; holds PC, IF/ID and ID/EX
Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out, Ctl_MemWrite_out, Ctl_Branch_out  out  1 each  EX/MEM controls
Rd_out  out  5  EX/MEM rd
Zero_out  out  1  EX/MEM: ALU result == 0
ALUresult_out  out  XLEN  EX/MEM ALU/MUL result
Write_Data_out  out  XLEN  EX/MEM store data (operand B before the ALUSrc mux)
PCimm_out  out  XLEN  EX/MEM: PC_in + (Immediate_in << 1)

Behaviour:
- Reset (async): every output register is 0, FSM = IDLE, iteration counter = 0.
- ALU decode:
  - ALUOp 00 → add; 01 → sub.
  - ALUOp 10 uses funct7/funct3: add, sub (f7=0100000), sll, slt, sltu, xor, srl, sra, or, and.
  - ALUOp 11: same as R-type, but funct7 is ignored except f7[5] for srai; addi never subtracts.
- Shift amount = operand B [4:0]. slt is signed, sltu unsigned. Add/sub wrap modulo 2^XLEN.
- MUL is detected when ALUOp=10, funct7=0000001, funct3=000. Result = low XLEN bits of the product. Other M-ops execute as add; they are unsupported.
- Non-MUL latency: 1 cycle. The EX/MEM register updates every edge.
- MUL FSM: IDLE → BUSY → DONE.
  - IDLE, MUL presented: capture operands, go to BUSY, counter = XLEN-1, Stall_out=1, EX/MEM latches a bubble.
  - BUSY: one multiplier bit per cycle, Stall_out=1, EX/MEM bubble. Go to DONE when counter = 0.
  - DONE: Stall_out=0. EX/MEM latches the product plus the held controls. Next state IDLE.
- MUL timing: Stall_out is high for XLEN+1 cycles; the result is in EX/MEM XLEN+2 edges after the MUL enters EX.
- A MUL still presented in DONE does not retrigger.
- Bubble: all five Ctl_*_out = 0. Data fields are don't-care; the RTL drives 0.
- Flush_in = 1: EX/MEM latches a bubble and the FSM returns to IDLE. Flush wins over DONE and over a new MUL. Stall_out = 0 while Flush_in = 1.
- Reset mid-MUL: abort, no result, all outputs 0.
- Back-to-back MULs: the second is detected in the cycle after DONE.

Optional Feature:
- Macro: EX_FWD_EN.
- Defined: adds ports ForwardA, ForwardB (in, 2 bits) and Fwd_MEM_data, Fwd_WB_data (in, XLEN).
  - Select codes: 00 register file, 10 MEM, 01 WB.
  - The forwarded rs2 feeds both Write_Data_out and operand B.
  - MUL operands are captured post-forwarding in IDLE.
- Undefined: ports absent; operands come straight from ReadData1_in / ReadData2_in.

Decomposition:
- Package ex_pkg:
  - ALUOp encodings, funct3/funct7 constants.
  - alu_ctl_t enum.
  - mul_state_t {IDLE, BUSY, DONE}.
  - Forward select codes.
- Sub-module ex_mul_seq: iterative shift-add multiplier.
  - Inputs: start, a, b, abort.
  - Outputs: busy, done, product.
  - Top-level execute owns the ALU, the stall logic and the EX/MEM register.

Test Plan:
- Reset while MUL BUSY (cycle 5) → all outputs 0, Stall_out=0 the same cycle, next instruction handled normally.
- ALUOp=10, f7=0100000, f3=000, rs1=5, rs2=7, Rd=3, RegWrite=1 → next edge ALUresult_out=0xFFFFFFFE, Zero_out=0, Rd_out=3.
- beq: ALUOp=01, rs1=rs2=0x1234, Branch=1, PC=0x100, imm=8 → Zero_out=1, Ctl_Branch_out=1, PCimm_out=0x110.
- MUL rs1=6, rs2=7 → Stall_out high 33 cycles, 33 bubbles in EX/MEM, then ALUresult_out=42 with RegWrite=1; MUL 0xFFFFFFFF×2 → 0xFFFFFFFE.
- MUL in BUSY, Flush_in=1 at cycle 10 → bubble latched, Stall_out=0, FSM IDLE, no result ever written.
- EX_FWD_EN: ForwardA=10, Fwd_MEM_data=100, rs1=1, rs2=1, add → ALUresult_out=101; sw with ForwardB=01, Fwd_WB_data=0xAB → Write_Data_out=0xAB.
